ssp_rx_ctrl: RTL and testbench
==============================

# ssp_rx_ctrl

Serial receive controller for the Synchronous Serial Port. Samples the external serial clock, frame sync and data lines in the pclk domain, assembles 8-bit frames MSB-first, and sequences writes into the RxFIFO through its w_en/rxdata inputs. It also detects RxFIFO overruns using the FIFO's ssprxintr (full) flag.

## Interface
Parameters:
- DATA_W, 8, frame width in bits; fixed at 8 in this design.

Ports:
- pclk  in  1  system clock; all logic on rising edge.
- clear_b  in  1  reset, asynchronous, active-low.
- sspclkin  in  1  external serial clock, asynchronous to pclk; high and low phases each ≥ 2 pclk periods.
- sspfssin  in  1  frame sync, high for one sspclkin period; sampled on sspclkin rising edge.
- ssprxd  in  1  serial receive data, MSB first; sampled on sspclkin rising edge.
- rx_full  in  1  RxFIFO full flag (ssprxintr).
- ovr_clr  in  1  one-cycle pulse that clears rx_overrun.
- w_en  out  1  RxFIFO write strobe, one pclk wide.
- rxdata  out  8  byte presented to RxFIFO; stable while w_en=1.
- rx_overrun  out  1  sticky: a completed frame was dropped because the FIFO was full.
- rx_busy  out  1  high while a frame is in progress or being written.

## Operation
- Synchronizers: two-flop synchronizer on each of sspclkin, sspfssin and ssprxd. A third flop on synced sspclkin drives the rise-edge detect: rise = s2 & ~s3. All FSM decisions use synced sspfssin/ssprxd, qualified by rise.
- Registers: shift register sh[6:0], bit counter cnt[2:0], start-pending flag sp, state.
- FSM states: IDLE, SHIFT, WRITE.
  - IDLE: on rise with fss=1, clear cnt and enter SHIFT. The fss edge carries no data bit.
  - SHIFT, on rise with cnt<7: sh <= {sh[5:0], rxd}, cnt <= cnt+1. If fss=1 at the same rise (mid-frame resync), discard the partial frame, set cnt=0, stay in SHIFT, and do not write or flag.
  - SHIFT, on rise with cnt==7 (LSB): rxdata <= {sh[6:0], rxd}, sp <= fss, enter WRITE.
  - WRITE (exactly 1 cycle): w_en = ~rx_full. If rx_full=1, set rx_overrun and drop the byte. Next state is SHIFT with cnt=0 if sp=1 (back-to-back frame), else IDLE. Clear sp.
- w_en is decoded from registered state and rx_full only.
- rx_overrun: set wins over ovr_clr when both occur in the same cycle.
- rx_busy = (state != IDLE).
- rxdata holds the last assembled byte until the next LSB capture, including after a dropped frame.

## Timing
- Reset values: w_en=0, rxdata=8'h00, rx_overrun=0, rx_busy=0. state=IDLE, cnt=0, sp=0, sh=0, all synchronizer flops=0.
- Reset asserted mid-frame: immediate abort. No w_en is generated after release. A new frame requires a fresh fss.
- Latency: rise is detected in the cycle after the 2nd pclk edge following the sspclkin pin rise. State/data update on the 3rd edge. For the LSB, w_en is high from the 3rd to the 4th pclk edge after the pin edge.
- Because rise events are ≥ 4 pclk apart, WRITE always completes before the next sample. Back-to-back frames lose no bits.
- rx_full is sampled only in WRITE. Its value at other times is ignored.
- Max serial rate: pclk/4.

## Test plan
- Single frame: pclk period 10 ns, sspclkin period 80 ns. Pulse fss, then shift 0xA5 -> exactly one w_en pulse with rxdata=8'hA5, rx_overrun=0, and rx_busy low after WRITE.
- Back-to-back: frames 0x3C then 0xC3, with fss high during the LSB period of the first -> two w_en pulses, rxdata 8'h3C then 8'hC3. rx_busy stays high between them.
- Overrun: rx_full=1 through frame 0x7E -> no w_en, rx_overrun=1, rxdata=8'h7E. Pulse ovr_clr -> rx_overrun=0. Assert ovr_clr in the same cycle as a new overrun -> rx_overrun stays 1.
- Mid-frame resync: fss after 4 bits, then full frame 0x81 -> one w_en only, rxdata=8'h81.
- Reset mid-frame: drop clear_b after 5 bits -> all outputs 0 immediately. After release, 3 more bits without fss -> no w_en, rx_busy=0.
- Idle noise: sspclkin toggling with fss=0 and random ssprxd for 20 periods -> w_en never asserted, rx_busy=0.

Source files
------------

// File: rtl/ssp_rx_ctrl.sv
// ssp_rx_ctrl: SSP serial receive controller.
// Synchronises the external serial clock, frame sync and data into pclk,
// assembles MSB-first bytes and issues one-cycle writes to the RxFIFO,
// flagging a sticky overrun when a completed byte meets a full FIFO.
module ssp_rx_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              pclk,
   input  logic              clear_b,
   input  logic              sspclkin,
   input  logic              sspfssin,
   input  logic              ssprxd,
   input  logic              rx_full,
   input  logic              ovr_clr,
   output logic              w_en,
   output logic [DATA_W-1:0] rxdata,
   output logic              rx_overrun,
   output logic              rx_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic              clk_s1, clk_s2, clk_s3;
   logic              fss_s1, fss_s2;
   logic              rxd_s1, rxd_s2;
   logic              rise;
   logic [DATA_W-2:0] sh, sh_nxt;
   logic [2:0]        cnt, cnt_nxt;
   logic              sp, sp_nxt;
   logic [DATA_W-1:0] rxdata_nxt;
   logic              ovr_set;

   // Two-flop synchronisers, plus a third stage on the clock for edge detect
   always_ff @(posedge pclk or negedge clear_b) begin
      if (!clear_b) begin
         clk_s1 <= 1'b0;
         clk_s2 <= 1'b0;
         clk_s3 <= 1'b0;
         fss_s1 <= 1'b0;
         fss_s2 <= 1'b0;
         rxd_s1 <= 1'b0;
         rxd_s2 <= 1'b0;
      end else begin
         clk_s1 <= sspclkin;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         fss_s1 <= sspfssin;
         fss_s2 <= fss_s1;
         rxd_s1 <= ssprxd;
         rxd_s2 <= rxd_s1;
      end
   end

   assign rise = clk_s2 & ~clk_s3;

   // State and datapath registers
   always_ff @(posedge pclk or negedge clear_b) begin
      if (!clear_b) begin
         state  <= IDLE;
         sh     <= '0;
         cnt    <= '0;
         sp     <= 1'b0;
         rxdata <= '0;
      end else begin
         state  <= state_nxt;
         sh     <= sh_nxt;
         cnt    <= cnt_nxt;
         sp     <= sp_nxt;
         rxdata <= rxdata_nxt;
      end
   end

   // Sticky overrun; a new overrun takes priority over a clear request
   always_ff @(posedge pclk or negedge clear_b) begin
      if (!clear_b) begin
         rx_overrun <= 1'b0;
      end else if (ovr_set) begin
         rx_overrun <= 1'b1;
      end else if (ovr_clr) begin
         rx_overrun <= 1'b0;
      end
   end

   // Next-state, shift/count update and FIFO write decode
   always_comb begin
      state_nxt  = state;
      sh_nxt     = sh;
      cnt_nxt    = cnt;
      sp_nxt     = sp;
      rxdata_nxt = rxdata;
      ovr_set    = 1'b0;
      w_en       = 1'b0;
      case (state)
         IDLE: begin
            // The frame-sync edge itself carries no data bit
            if (rise && fss_s2) begin
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (rise) begin
               if (cnt == 3'd7) begin
                  rxdata_nxt = {sh, rxd_s2};
                  sp_nxt     = fss_s2;
                  state_nxt  = WRITE;
               end else if (fss_s2) begin
                  // Resync: drop the partial frame and restart the count
                  cnt_nxt = '0;
               end else begin
                  sh_nxt  = {sh[DATA_W-3:0], rxd_s2};
                  cnt_nxt = cnt + 3'd1;
               end
            end
         end
         WRITE: begin
            w_en      = ~rx_full;
            ovr_set   = rx_full;
            cnt_nxt   = '0;
            sp_nxt    = 1'b0;
            state_nxt = sp ? SHIFT : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// tb_ssp_rx_ctrl: scoreboard bench for ssp_rx_ctrl.
// Stimulus pushes each byte that must reach the FIFO; a monitor pops and
// compares on every w_en, flagging any write that was not expected.
module tb_ssp_rx_ctrl;

   logic       pclk = 1'b0;
   logic       clear_b;
   logic       sspclkin;
   logic       sspfssin;
   logic       ssprxd;
   logic       rx_full;
   logic       ovr_clr;
   logic       w_en;
   logic [7:0] rxdata;
   logic       rx_overrun;
   logic       rx_busy;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];

   ssp_rx_ctrl #(.DATA_W(8)) dut (
      .pclk       (pclk),
      .clear_b    (clear_b),
      .sspclkin   (sspclkin),
      .sspfssin   (sspfssin),
      .ssprxd     (ssprxd),
      .rx_full    (rx_full),
      .ovr_clr    (ovr_clr),
      .w_en       (w_en),
      .rxdata     (rxdata),
      .rx_overrun (rx_overrun),
      .rx_busy    (rx_busy)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write must match the oldest expected byte
   always @(negedge pclk) begin
      if (w_en === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_wen: got rxdata %0h expected no write at %0t", rxdata, $time);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rxdata !== e) begin
               n_bad++;
               $display("FAIL wen_data: got %0h expected %0h at %0t", rxdata, e, $time);
            end
         end
      end
   end

   // One serial bit: 40 ns low with data set up, 40 ns high; all edges on
   // negedge pclk so the WRITE cycle falls on a known pclk slot.
   task automatic send_bit(input logic fss, input logic d, input logic clr);
      sspclkin = 1'b0;
      sspfssin = fss;
      ssprxd   = d;
      repeat (4) @(negedge pclk);
      sspclkin = 1'b1;
      for (int unsigned k = 1; k <= 4; k++) begin
         @(negedge pclk);
         // Covers the WRITE cycle that follows the LSB rise
         ovr_clr = clr && (k == 2 || k == 3);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic lsb_fss,
                             input logic expect_wr, input logic clr_lsb);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && expect_wr) exp_q.push_back(b);
         send_bit((i == 0) ? lsb_fss : 1'b0, b[i], (i == 0) ? clr_lsb : 1'b0);
      end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_b  = 1'b0;
      sspclkin = 1'b0;
      sspfssin = 1'b0;
      ssprxd   = 1'b0;
      rx_full  = 1'b0;
      ovr_clr  = 1'b0;
      repeat (3) @(negedge pclk);
      check("rst_wen", w_en, 0);
      check("rst_rxdata", rxdata, 8'h00);
      check("rst_ovr", rx_overrun, 0);
      check("rst_busy", rx_busy, 0);
      clear_b = 1'b1;
      repeat (2) @(negedge pclk);

      // Single frame
      send_bit(1'b1, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      check("single_busy", rx_busy, 0);
      check("single_ovr", rx_overrun, 0);
      check("single_rxdata", rxdata, 8'hA5);

      // Back-to-back frames
      send_bit(1'b1, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
      check("b2b_busy_between", rx_busy, 1);
      send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
      check("b2b_busy_end", rx_busy, 0);
      check("b2b_rxdata", rxdata, 8'hC3);

      // Overrun with FIFO full
      rx_full = 1'b1;
      send_bit(1'b1, 1'b0, 1'b0);
      send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
      check("ovr_set", rx_overrun, 1);
      check("ovr_rxdata", rxdata, 8'h7E);
      rx_full = 1'b0;
      ovr_clr = 1'b1;
      @(negedge pclk);
      ovr_clr = 1'b0;
      @(negedge pclk);
      check("ovr_cleared", rx_overrun, 0);
      // Clear requested in the same cycle as a new overrun
      rx_full = 1'b1;
      send_bit(1'b1, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      check("ovr_set_wins", rx_overrun, 1);
      check("ovr2_rxdata", rxdata, 8'h55);
      rx_full = 1'b0;

      // Mid-frame resync
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b1, 1'b0);
      check("resync_rxdata", rxdata, 8'h81);
      check("resync_busy", rx_busy, 0);

      // Reset mid-frame
      send_bit(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, 1'b0);
      clear_b = 1'b0;
      #1;
      check("midrst_wen", w_en, 0);
      check("midrst_rxdata", rxdata, 8'h00);
      check("midrst_ovr", rx_overrun, 0);
      check("midrst_busy", rx_busy, 0);
      @(negedge pclk);
      clear_b = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 1'b0);
      check("postrst_busy", rx_busy, 0);

      // Idle noise without frame sync
      for (int i = 0; i < 20; i++) begin
         send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         if (i % 5 == 4) check("noise_busy", rx_busy, 0);
      end
      repeat (4) @(negedge pclk);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
